// File: rtl/s2p_pkg.sv
// Shared types for the serial link: FSM state encoding and default word width.
// Used by parallel_serial_tx and the serial-to-parallel receiver.
package s2p_pkg;

   localparam int DEFAULT_BITS = 4;

   typedef enum logic [1:0] {
      IDLE,
      SHIFT,
      PARITY
   } p2s_state_e;

endpackage

// File: rtl/p2s_shifter.sv
// BITS-wide shift register: parallel load, left shift with zero fill, MSB tap.
module p2s_shifter
   import s2p_pkg::*;
#(
   parameter int BITS = DEFAULT_BITS
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            load_i,
   input  logic            shift_i,
   input  logic [BITS-1:0] data_i,
   output logic            msb_o
);

   logic [BITS-1:0] sr_q;
   logic [BITS-1:0] sr_d;

   // NOTE: sr_d gets a default before any branch so the block infers no latch.
   always_comb begin
      sr_d = sr_q;
      if (load_i) begin
         sr_d = data_i;
      end else if (shift_i) begin
         sr_d = {sr_q[BITS-2:0], 1'b0};
      end
   end

   // NOTE: sequential state is written with non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         sr_q <= '0;
      end else begin
         sr_q <= sr_d;
      end
   end

   assign msb_o = sr_q[BITS-1];

endmodule

// File: rtl/parallel_serial_tx.sv
// Parallel-to-serial transmitter, MSB first, with valid/ready word intake.
// Define P2S_PARITY_EN to append an even-parity bit to every frame.
module parallel_serial_tx
   import s2p_pkg::*;
#(
   parameter int BITS = DEFAULT_BITS
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [BITS-1:0] parallel_in,
   input  logic            load,
   output logic            ready,
   output logic            serial_out,
   output logic            serial_valid,
   output logic            busy,
   output logic            done
);

   localparam int CNT_W = (BITS > 1) ? $clog2(BITS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BITS - 1);

   p2s_state_e     state_q;
   logic [CNT_W-1:0] cnt_q;
   logic           last_bit;
   logic           frame_end;
   logic           accept;
   logic           shift_msb;

   assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_CNT);

`ifdef P2S_PARITY_EN
   logic parity_q;
   assign frame_end = (state_q == PARITY);
`else
   assign frame_end = last_bit;
`endif

   // The final slot of a frame already accepts the next word: zero-gap streaming.
   assign ready        = (state_q == IDLE) || frame_end;
   assign accept       = load && ready;
   assign done         = frame_end;
   assign busy         = (state_q != IDLE);
   assign serial_valid = busy;

   p2s_shifter #(
      .BITS (BITS)
   ) u_shifter (
      .clk     (clk),
      .reset   (reset),
      .load_i  (accept),
      .shift_i (state_q == SHIFT),
      .data_i  (parallel_in),
      .msb_o   (shift_msb)
   );

   always_comb begin
      serial_out = 1'b0;
      if (state_q == SHIFT) begin
         serial_out = shift_msb;
      end
`ifdef P2S_PARITY_EN
      if (state_q == PARITY) begin
         serial_out = parity_q;
      end
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
`ifdef P2S_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else if (accept) begin
         state_q  <= SHIFT;
         cnt_q    <= '0;
`ifdef P2S_PARITY_EN
         parity_q <= ^parallel_in;
`endif
      end else begin
         case (state_q)
            SHIFT: begin
               if (last_bit) begin
`ifdef P2S_PARITY_EN
                  state_q <= PARITY;
`else
                  state_q <= IDLE;
`endif
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/parallel_serial_tx.md
Name: parallel_serial_tx

Overview:
- Parallel-to-serial transmitter; the sending end of the serial link our serial-to-parallel receiver consumes.
- Accepts a BITS-wide word through a valid/ready handshake and shifts it out one bit per clk, MSB first.
- After BITS shifts, a receiver clocked on the same clk holds the original word on its parallel output.
- Sits between the tt_um top-level IO mapping and the link pins, alongside the receiver.

Parameters:
BITS, 4, word width; legal range BITS >= 2; matches the receiver's bits parameter

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  synchronous, active-high reset
parallel_in  input  BITS  word to transmit; sampled only on the accept edge
load  input  1  word valid; accepted on an edge where load && ready
ready  output  1  transmitter can accept a word this cycle
serial_out  output  1  serial data, MSB first
serial_valid  output  1  serial_out carries a frame bit this cycle
busy  output  1  frame in progress
done  output  1  one-cycle pulse on the last bit of a frame

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values:
  - State = IDLE; shift register = 0; counter = 0.
  - serial_out = 0, serial_valid = 0, busy = 0, done = 0, ready = 1.
- Reset mid-frame: the frame is aborted. Outputs take their reset values on the cycle after the reset edge. No done pulse is produced.
- Reset has priority over load.
- States: IDLE, SHIFT (plus PARITY when P2S_PARITY_EN is defined).
- IDLE:
  - ready = 1; serial_out = 0; serial_valid = 0.
  - load = 1 at edge N latches parallel_in into the shift register, clears the counter, and moves to SHIFT.
- SHIFT:
  - Cycles N+1 through N+BITS drive serial_out = shift register MSB, i.e. d[BITS-1], d[BITS-2], ..., d[0].
  - serial_valid = 1 and busy = 1 throughout.
  - Each edge shifts the register left by one (zero fill) and increments the counter.
- Last data bit (counter == BITS-1):
  - done = 1 and ready = 1, both combinational from state and counter.
  - load = 1 on that edge: the new word is accepted and SHIFT restarts with a zero-cycle gap (back-to-back frames).
  - load = 0 on that edge: next state is IDLE.
- load while ready = 0: ignored; parallel_in changes during a frame have no effect.
- Latency: first bit appears 1 cycle after accept; frame length is BITS cycles; sustained throughput is 1 bit per clk.
- Counter: width $clog2(BITS); never wraps past BITS-1 because the last-bit compare ends or restarts the frame.
- busy = serial_valid = (state != IDLE).

Optional Feature:
- Macro: P2S_PARITY_EN.
- Defined:
  - After the last data bit the FSM enters PARITY for one cycle.
  - In that cycle serial_out = XOR of the accepted word (even parity) and serial_valid = 1.
  - done and ready move from the last data bit to the PARITY cycle; back-to-back acceptance happens there.
  - Frame length is BITS+1; the parity bit is stored at accept, not recomputed.
- Undefined: no PARITY state, no parity storage; behaviour exactly as above.

Decomposition:
- Package s2p_pkg holds:
  - typedef enum for the FSM state (IDLE, SHIFT, PARITY);
  - localparam default width DEFAULT_BITS = 4.
  - The receiver shares the package.
- One natural sub-module, p2s_shifter: BITS-wide load/shift register with parallel-load, shift-enable and MSB tap.
- FSM, counter, handshake and parity logic stay in parallel_serial_tx.

Test Plan:
- BITS=4, load 4'b1011 accepted at cycle N -> serial_out 1,0,1,1 on N+1..N+4; serial_valid and busy high N+1..N+4; done only at N+4; ready low N+1..N+3; IDLE at N+5.
- Back-to-back: 4'b1011 then 4'b0110 offered at the N+4 ready cycle -> continuous stream 1,0,1,1,0,1,1,0 with no gap; done at N+4 and N+8.
- Load 4'b1111 held during frame of 4'b1001 (ready=0) -> stream stays 1,0,0,1; 4'b1111 sent only if load is still high at the ready cycle.
- Reset asserted at N+2 of 4'b1011 -> from N+3: serial_out=0, serial_valid=0, busy=0, ready=1, no done; next load 4'h5 transmits 0,1,0,1 cleanly.
- Loopback into the serial-to-parallel receiver (same clk, receiver samples when serial_valid): sending 4'hA, then 4'h3 -> receiver parallel_out reads 4'hA, then 4'h3, after each frame.
- P2S_PARITY_EN defined, 4'b1011 -> 1,0,1,1,1 (parity 1) with done on the 5th bit; 4'b0110 -> 0,1,1,0,0.
